shift_add_multiplier: RTL and testbench
=======================================

// Module: shift_add_multiplier
// PURPOSE
//  Sequential multiply-accumulate: p = a*b + addend, one multiplier bit per clock.
//  Inverse of the restoring divider: given divider outputs (q, r) and divisor b,
//  a*b + addend with a=q, addend=r reconstructs the dividend.
//  Used as the companion arithmetic unit and as a self-check for the divider.
//  Start/busy/done handshake; operands are captured when the start is accepted.
// PARAMETERS
//  WIDTH  32  operand width in bits; the result p is 2*WIDTH bits wide
// PORTS
//  clock   in   1        single clock, rising-edge active
//  reset   in   1        asynchronous, active-high; clears all state and outputs
//  start   in   1        level-sampled request; accepted only in IDLE
//  a       in   WIDTH    multiplicand, captured on accept
//  b       in   WIDTH    multiplier, captured on accept
//  addend  in   WIDTH    zero-extended accumulator seed, captured on accept
//  busy    out  1        high in RUN and DONE
//  done    out  1        one-cycle pulse; p is valid from this cycle onward
//  p       out  2*WIDTH  result; holds its value until the next done
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-high (port names clock and reset).
//  - Reset values: busy=0, done=0, p=0, state=IDLE, internal registers=0.
//  - States:
//    - IDLE: start=1 at an edge -> RUN.
//    - RUN: step counter k runs 0..WIDTH-1; after step WIDTH-1 -> DONE.
//    - DONE: lasts 1 cycle, then -> IDLE unconditionally.
//  - Accept edge E0: a_sh <= {0,a} (2*WIDTH bits), b_sh <= b,
//    acc <= {0,addend}, k <= 0.
//  - Each RUN edge:
//    - if b_sh[0]: acc <= acc + a_sh
//    - a_sh <= a_sh << 1; b_sh <= b_sh >> 1; k <= k+1
//  - Edge E_WIDTH: p <= final acc; done <= 1; state DONE.
//    done is high for the cycle following E_WIDTH.
//  - Latency: done rises WIDTH edges after the accept edge (E0).
//    Throughput: one operation per WIDTH+2 cycles; no early exit on zero operands.
//  - Width rule: (2^W-1)^2 + (2^W-1) < 2^(2W), so acc never overflows.
//    All arithmetic is unsigned and modulo 2^(2W).
//  - start is ignored while busy. Inputs may change freely after accept.
//    start held high continuously re-accepts on the first IDLE edge after DONE.
//  - b=0 gives p=addend; a=0 gives p=addend; both still take the full latency.
//  - Reset mid-RUN aborts immediately: p=0, no done pulse. start is honoured
//    on the first edge after reset deasserts.
//  - start asserted in the same cycle as done (DONE state) is not accepted.
// STRUCTURE
//  - Shared package arith_pkg: WIDTH default constant and the state enum
//    {IDLE, RUN, DONE}. The divider uses the same package.
//  - No sub-module: the shift/add datapath is a single 2*WIDTH adder, kept inline.
//  - Step counter is $clog2(WIDTH)+1 bits wide.
// TESTING
//  - a=6, b=7, addend=0 -> done at E32; p=42; busy high E0..E33.
//  - a=q=0x0000_0014, b=5, addend=r=3 (divider output for 103/5) -> p=103.
//  - a=b=addend=0xFFFF_FFFF -> p=0xFFFF_FFFF_0000_0000; no overflow.
//  - start pulsed again in RUN with new operands -> ignored; result matches
//    the first operands; exactly one done pulse.
//  - reset asserted at step 10 of a=3,b=3 -> p=0, busy=0 asynchronously.
//    Next start with a=2,b=9 -> p=18.
//  - start held high for 100 cycles with b=0, addend=17 -> done every 34 cycles;
//    p=17 each time.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic package for the divider/multiplier pair.
// Holds the default operand width and the sequencing state enum
// used by both sequential arithmetic units.
package arith_pkg;

  localparam int unsigned WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shift_add_multiplier.sv
// Sequential multiply-accumulate: p = a*b + addend, one multiplier bit per clock.
// Reconstructs a dividend from divider outputs (a=q, addend=r, b=divisor).
//
// Ports:
//   clock   in   1        rising-edge clock
//   reset   in   1        asynchronous active-high reset, clears all state
//   start   in   1        level-sampled request, accepted only in IDLE
//   a       in   WIDTH    multiplicand, captured on accept
//   b       in   WIDTH    multiplier, captured on accept
//   addend  in   WIDTH    zero-extended accumulator seed, captured on accept
//   busy    out  1        high in RUN and DONE
//   done    out  1        one-cycle pulse when p is updated
//   p       out  2*WIDTH  result, held until the next done
module shift_add_multiplier
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   addend,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  localparam int unsigned KW = $clog2(WIDTH) + 1;
  localparam logic [KW-1:0] K_LAST = KW'(WIDTH - 1);

  state_t             state;
  logic [2*WIDTH-1:0] a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [2*WIDTH-1:0] acc;
  logic [KW-1:0]      k;
  logic [2*WIDTH-1:0] acc_next;

  // Single shared adder; the last step's sum is written to p directly so
  // done lands exactly WIDTH edges after the accept edge.
  always_comb begin
    acc_next = acc;
    if (b_sh[0]) begin
      acc_next = acc + a_sh;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      k     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      p     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= {{WIDTH{1'b0}}, a};
            b_sh  <= b;
            acc   <= {{WIDTH{1'b0}}, addend};
            k     <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc  <= acc_next;
          a_sh <= a_sh << 1;
          b_sh <= b_sh >> 1;
          k    <= k + KW'(1);
          if (k == K_LAST) begin
            p     <= acc_next;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
module tb_shift_add_multiplier;

  localparam int unsigned W = 32;

  logic           clock;
  logic           reset;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [W-1:0]   addend;
  logic           busy;
  logic           done;
  logic [2*W-1:0] p;

  int n_vec = 0;
  int n_err = 0;
  int done_total = 0;

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .a      (a),
    .b      (b),
    .addend (addend),
    .busy   (busy),
    .done   (done),
    .p      (p)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: result is plain 2W-bit arithmetic computed at accept;
  // timing follows the stated latency (done WIDTH edges after accept, busy
  // through one more edge).
  logic           m_busy;
  logic           m_done;
  logic [2*W-1:0] m_p;
  logic [2*W-1:0] m_res;
  int             m_edges;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_busy  = 1'b0;
      m_done  = 1'b0;
      m_p     = '0;
      m_res   = '0;
      m_edges = 0;
    end else if (!m_busy) begin
      m_done = 1'b0;
      if (start) begin
        m_busy  = 1'b1;
        m_edges = 0;
        m_res   = 64'(a) * 64'(b) + 64'(addend);
      end
    end else begin
      m_edges++;
      if (m_edges == W) begin
        m_p    = m_res;
        m_done = 1'b1;
      end else if (m_edges == W + 1) begin
        m_done = 1'b0;
        m_busy = 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(posedge clock) begin
    #1;
    if (!reset) begin
      chk("cyc busy", 64'(busy), 64'(m_busy));
      chk("cyc done", 64'(done), 64'(m_done));
      chk("cyc p", p, m_p);
      if (done) done_total++;
    end
  end

  // Waits (bounded) for done after the accept edge has passed; returns edge count.
  task automatic wait_done(input string name, output int n);
    n = 0;
    forever begin
      @(posedge clock);
      n++;
      #1;
      if (done) break;
      if (n >= 200) begin
        chk({name, " timeout"}, 64'(0), 64'(1));
        break;
      end
    end
  endtask

  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic [W-1:0] iadd, input logic [2*W-1:0] exp,
                        input string name);
    int n;
    @(negedge clock);
    a = ia; b = ib; addend = iadd; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    a = $urandom; b = $urandom; addend = $urandom;
    chk({name, " busy@E0"}, 64'(busy), 64'(1));
    wait_done(name, n);
    chk({name, " latency"}, 64'(n), 64'(W));
    chk({name, " p"}, p, exp);
    @(posedge clock);
    #1;
    chk({name, " busy after"}, 64'(busy), 64'(0));
  endtask

  initial begin
    int n;
    int d0;
    int last;
    int ndone;
    logic [W-1:0] ra, rb, radd;

    reset = 1'b1; start = 1'b0; a = '0; b = '0; addend = '0;
    repeat (2) @(negedge clock);
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset done", 64'(done), 64'(0));
    chk("reset p", p, 64'(0));
    reset = 1'b0;

    run_op(32'd6, 32'd7, 32'd0, 64'd42, "6x7");
    run_op(32'h14, 32'd5, 32'd3, 64'd103, "div103");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_0000_0000, "allones");
    run_op(32'd0, 32'h1234_5678, 32'd9, 64'd9, "a0");
    run_op(32'h8765_4321, 32'd0, 32'd5, 64'd5, "b0");

    // start re-pulsed during RUN with new operands must be ignored
    @(negedge clock);
    a = 32'd11; b = 32'd13; addend = 32'd1; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    @(negedge clock);
    d0 = done_total;
    repeat (5) @(posedge clock);
    @(negedge clock);
    a = 32'd99; b = 32'd77; addend = 32'd5; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done("ignore", n);
    chk("ignore p", p, 64'd144);
    repeat (40) @(posedge clock);
    @(negedge clock);
    chk("ignore one done", 64'(done_total - d0), 64'(1));

    // asynchronous reset mid-RUN
    @(negedge clock);
    a = 32'd3; b = 32'd3; addend = 32'd0; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("abort busy", 64'(busy), 64'(0));
    chk("abort done", 64'(done), 64'(0));
    chk("abort p", p, 64'(0));
    @(negedge clock);
    reset = 1'b0;
    run_op(32'd2, 32'd9, 32'd0, 64'd18, "after reset");

    // start held high: back-to-back operations every W+2 cycles
    @(negedge clock);
    a = $urandom; b = 32'd0; addend = 32'd17; start = 1'b1;
    last = -1;
    ndone = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(posedge clock);
      #1;
      if (done) begin
        ndone++;
        chk("held p", p, 64'd17);
        if (last >= 0) chk("held spacing", 64'(cyc - last), 64'(W + 2));
        last = cyc;
      end
    end
    chk("held count", 64'(ndone), 64'(2));
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("held drain", 64'(busy), 64'(0));

    // randomized operations
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      radd = $urandom;
      if (i % 4 == 1) rb = rb & 32'h0000_00FF;
      if (i % 4 == 2) ra = ra >> (i % 31);
      run_op(ra, rb, radd, 64'(ra) * 64'(rb) + 64'(radd), "rand");
    end

    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
